// File: rtl/dphy_pkg.sv
// rtl/dphy_pkg.sv - shared D-PHY constants and HS lane sequencer state type
// Shared by the HS lane transmitter and the RX byte aligner.
package dphy_pkg;

   localparam logic [7:0] SYNC_PATTERN = 8'hB8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ZERO  = 3'd1,
      ST_DATA  = 3'd2,
      ST_TRAIL = 3'd3,
      ST_GAP   = 3'd4
   } hs_state_e;

endpackage

// File: rtl/dphy_hs_lane_tx.sv
// rtl/dphy_hs_lane_tx.sv - D-PHY HS byte sequencer for one data lane
// Frames a payload burst as HS-ZERO leader, sync byte, payload, and HS-TRAIL.
module dphy_hs_lane_tx
   import dphy_pkg::*;
#(
   parameter int ZERO_BYTES  = 4,
   parameter int TRAIL_BYTES = 2
)(
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   input  logic       tx_last_i,
   output logic       tx_ready_o,
   output logic [7:0] hs_byte_o,
   output logic       hs_active_o,
   output logic       busy_o,
   output logic       underflow_o
);

   localparam int CNT_MAX = (ZERO_BYTES > TRAIL_BYTES) ? ZERO_BYTES : TRAIL_BYTES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] ZERO_LOAD     = CW'(ZERO_BYTES);
   localparam logic [CW-1:0] TRAIL_LOAD    = CW'(TRAIL_BYTES);
   // An underflow emits its first trail byte on the detecting edge.
   localparam logic [CW-1:0] TRAIL_LOAD_UF = CW'(TRAIL_BYTES - 1);
   localparam logic [CW-1:0] CNT_ONE       = CW'(1);

   hs_state_e     r_state;
   hs_state_e     w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic [7:0]    r_last_byte;
   logic [7:0]    w_last_byte_nxt;
   logic [7:0]    r_hs_byte;
   logic [7:0]    w_hs_byte_nxt;
   logic          r_hs_active;
   logic          w_hs_active_nxt;
   logic [7:0]    w_trail_byte;

   assign w_trail_byte = {8{~r_last_byte[7]}};

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_last_byte <= '0;
         r_hs_byte   <= '0;
         r_hs_active <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_last_byte <= w_last_byte_nxt;
         r_hs_byte   <= w_hs_byte_nxt;
         r_hs_active <= w_hs_active_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_last_byte_nxt = r_last_byte;
      w_hs_byte_nxt   = 8'h00;
      w_hs_active_nxt = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (tx_valid_i) begin
               w_state_nxt = ST_ZERO;
               w_cnt_nxt   = ZERO_LOAD;
            end
         end

         ST_ZERO: begin
            w_hs_active_nxt = 1'b1;
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - CNT_ONE;
            end else begin
               w_hs_byte_nxt   = SYNC_PATTERN;
               w_last_byte_nxt = SYNC_PATTERN;
               w_state_nxt     = ST_DATA;
            end
         end

         ST_DATA: begin
            w_hs_active_nxt = 1'b1;
            if (tx_valid_i) begin
               w_hs_byte_nxt   = tx_data_i;
               w_last_byte_nxt = tx_data_i;
               if (tx_last_i) begin
                  w_state_nxt = ST_TRAIL;
                  w_cnt_nxt   = TRAIL_LOAD;
               end
            end else begin
               w_hs_byte_nxt = w_trail_byte;
               w_state_nxt   = ST_TRAIL;
               w_cnt_nxt     = TRAIL_LOAD_UF;
            end
         end

         ST_TRAIL: begin
            if (r_cnt != '0) begin
               w_hs_active_nxt = 1'b1;
               w_hs_byte_nxt   = w_trail_byte;
               w_cnt_nxt       = r_cnt - CNT_ONE;
            end else begin
               w_state_nxt = ST_GAP;
            end
         end

         ST_GAP: begin
            w_state_nxt = ST_IDLE;
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign tx_ready_o  = (r_state == ST_DATA);
   assign underflow_o = (r_state == ST_DATA) && !tx_valid_i;
   assign busy_o      = (r_state != ST_IDLE);
   assign hs_byte_o   = r_hs_byte;
   assign hs_active_o = r_hs_active;

endmodule

// File: tb/tb_dphy_hs_lane_tx.sv
// tb/tb_dphy_hs_lane_tx.sv - scoreboard bench for the D-PHY HS lane transmitter
// Expected lane bursts are built from the framing rules and drained by a monitor.
module tb_dphy_hs_lane_tx;

   localparam int ZB = 4;
   localparam int TB = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_last;
   logic       tx_ready;
   logic [7:0] hs_byte;
   logic       hs_active;
   logic       busy;
   logic       underflow;

   int checks   = 0;
   int failures = 0;

   logic [7:0] exp_q[$];
   int         len_q[$];
   logic [7:0] cur[$];
   int         uf_expected = 0;
   int         uf_seen     = 0;

   always #5 clk = ~clk;

   dphy_hs_lane_tx #(.ZERO_BYTES(ZB), .TRAIL_BYTES(TB)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .tx_data_i   (tx_data),
      .tx_valid_i  (tx_valid),
      .tx_last_i   (tx_last),
      .tx_ready_o  (tx_ready),
      .hs_byte_o   (hs_byte),
      .hs_active_o (hs_active),
      .busy_o      (busy),
      .underflow_o (underflow)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every active lane byte must match the next scoreboard entry.
   logic mon_prev   = 1'b0;
   int   mon_run    = 0;
   int   mon_gap    = 0;
   bit   mon_seen   = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         mon_prev = 1'b0;
         mon_run  = 0;
         mon_gap  = 0;
         mon_seen = 1'b0;
      end else begin
         if (underflow) uf_seen++;
         if (hs_active) begin
            if (!mon_prev && mon_seen) check("idle_gap_ge3", 32'(mon_gap >= 3), 32'd1);
            if (exp_q.size() == 0) begin
               check("unexpected_active_byte", {24'd0, hs_byte}, 32'hFFFF_FFFF);
            end else begin
               check("lane_byte", {24'd0, hs_byte}, {24'd0, exp_q.pop_front()});
            end
            mon_run++;
         end else begin
            if (mon_prev) begin
               if (len_q.size() == 0) check("unexpected_burst_end", 32'(mon_run), 32'hFFFF_FFFF);
               else                   check("burst_length", 32'(mon_run), 32'(len_q.pop_front()));
               mon_run  = 0;
               mon_gap  = 0;
               mon_seen = 1'b1;
            end
            mon_gap++;
            check("idle_byte_zero", {24'd0, hs_byte}, 32'd0);
         end
         mon_prev = hs_active;
      end
   end

   // Reference framing: leader, sync, bytes actually sent, trail from the last bit sent.
   task automatic push_expected(input int uf_at);
      int         n;
      logic [7:0] lastb;
      n = (uf_at < 0) ? cur.size() : uf_at;
      for (int i = 0; i < ZB; i++) exp_q.push_back(8'h00);
      exp_q.push_back(8'hB8);
      for (int i = 0; i < n; i++) exp_q.push_back(cur[i]);
      lastb = (n == 0) ? 8'hB8 : cur[n-1];
      for (int i = 0; i < TB; i++) exp_q.push_back(lastb[7] ? 8'h00 : 8'hFF);
      len_q.push_back(ZB + 1 + n + TB);
   endtask

   task automatic wait_idle();
      int cyc = 0;
      while (busy && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("idle_timeout", 32'(busy), 32'd0);
   endtask

   // Drives cur[] as one burst; uf_at<0 sends it all, else valid drops after uf_at bytes.
   task automatic run_burst(input int uf_at, input bit b2b);
      int idx = 0;
      int cyc = 0;
      bit done = 1'b0;
      push_expected(uf_at);
      if (uf_at >= 0) uf_expected++;
      tx_valid = 1'b1;
      tx_data  = cur[0];
      tx_last  = (cur.size() == 1);
      @(posedge clk); #1;
      while (!done) begin
         if (cyc > 200) begin
            check("burst_timeout", 32'(cyc), 32'd0);
            tx_valid = 1'b0;
            break;
         end
         if (tx_ready && uf_at == idx) begin
            tx_valid = 1'b0;
            @(posedge clk); #1;
            done = 1'b1;
         end else if (tx_ready) begin
            @(posedge clk); #1;
            cyc++;
            idx++;
            if (idx == cur.size()) begin
               done     = 1'b1;
               tx_valid = b2b;
            end else begin
               tx_data = cur[idx];
               tx_last = (idx == cur.size() - 1);
            end
         end else begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      if (!b2b) begin
         tx_valid = 1'b0;
         wait_idle();
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_hs_active"}, 32'(hs_active), 32'd0);
      check({tag, "_hs_byte"},   {24'd0, hs_byte}, 32'd0);
      check({tag, "_tx_ready"},  32'(tx_ready), 32'd0);
      check({tag, "_busy"},      32'(busy), 32'd0);
      check({tag, "_underflow"}, 32'(underflow), 32'd0);
   endtask

   initial begin
      int len;
      int uf;
      int cyc;
      rst_n    = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      tx_last  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      cur = '{8'h11, 8'h22, 8'h83}; run_burst(-1, 1'b0);
      cur = '{8'h05, 8'h7F};        run_burst(-1, 1'b0);
      cur = '{8'h7F};               run_burst(-1, 1'b0);
      cur = '{8'h11, 8'h22, 8'h83}; run_burst(2, 1'b0);
      cur = '{8'h11, 8'h22, 8'h83}; run_burst(0, 1'b0);
      cur = '{8'hA5, 8'h3C};        run_burst(-1, 1'b1);
      cur = '{8'h80};               run_burst(-1, 1'b0);

      for (int b = 0; b < 30; b++) begin
         len = $urandom_range(1, 6);
         cur.delete();
         for (int i = 0; i < len; i++) cur.push_back(8'($urandom));
         uf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
         run_burst(uf, ($urandom_range(0, 2) == 0));
      end
      tx_valid = 1'b0;
      wait_idle();

      // Asynchronous reset landing between edges in the middle of the payload.
      cur = '{8'h5A, 8'h6B, 8'h7C};
      push_expected(-1);
      tx_valid = 1'b1;
      tx_data  = 8'h5A;
      tx_last  = 1'b0;
      cyc = 0;
      while (!tx_ready && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("reach_data_before_reset", 32'(tx_ready), 32'd1);
      @(posedge clk); #1;
      tx_data = 8'h6B;
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      tx_valid = 1'b0;
      exp_q.delete();
      len_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      cur = '{8'hC3, 8'h01}; run_burst(-1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      check("lengths_drained",    32'(len_q.size()), 32'd0);
      check("underflow_pulses",   32'(uf_seen), 32'(uf_expected));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
